// File: rtl/pipe_csel_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 builds per-segment candidate sums; stage 2 resolves the select chain.
module pipe_csel_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSEG = WIDTH / SEG;

  if (SEG < 2 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipe_csel_adder: WIDTH must be a multiple of SEG and SEG must be >= 2");
  end

  // Handshake: each stage moves when it is empty or its consumer takes the beat
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = s2_valid;

  // Subtraction is x + ~y + 1, so the external carry-in is overridden
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [SEG-1:0]   lo_sum_d;
  logic             lo_c_d;

  assign b_eff = sub ? ~y : y;
  assign c_eff = sub | cin;
  assign {lo_c_d, lo_sum_d} = (SEG+1)'(x[SEG-1:0]) + (SEG+1)'(b_eff[SEG-1:0])
                            + (SEG+1)'(c_eff);

  logic [SEG-1:0]   s1_lo_sum;
  logic             s1_lo_c;
  logic             s1_a_msb;
  logic             s1_b_msb;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo_sum <= '0;
      s1_lo_c   <= 1'b0;
      s1_a_msb  <= 1'b0;
      s1_b_msb  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_lo_sum <= lo_sum_d;
        s1_lo_c   <= lo_c_d;
        s1_a_msb  <= x[WIDTH-1];
        s1_b_msb  <= b_eff[WIDTH-1];
      end
    end
  end

  if (NSEG > 1) begin : g_csel
    logic [NSEG-1:1][SEG-1:0] cand0_d;
    logic [NSEG-1:1][SEG-1:0] cand1_d;
    logic [NSEG-1:1]          c0_d;
    logic [NSEG-1:1]          c1_d;
    logic [NSEG-1:1][SEG-1:0] s1_cand0;
    logic [NSEG-1:1][SEG-1:0] s1_cand1;
    logic [NSEG-1:1]          s1_c0;
    logic [NSEG-1:1]          s1_c1;
    logic [NSEG-1:0]          carry;

    // Upper segments precompute both carry-in outcomes
    for (genvar k = 1; k < NSEG; k++) begin : g_seg
      logic [SEG-1:0] xa;
      logic [SEG-1:0] yb;
      assign xa = x[k*SEG +: SEG];
      assign yb = b_eff[k*SEG +: SEG];
      assign {c0_d[k], cand0_d[k]} = (SEG+1)'(xa) + (SEG+1)'(yb);
      assign {c1_d[k], cand1_d[k]} = (SEG+1)'(xa) + (SEG+1)'(yb) + (SEG+1)'(1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_cand0 <= '0;
        s1_cand1 <= '0;
        s1_c0    <= '0;
        s1_c1    <= '0;
      end else if (accept) begin
        s1_cand0 <= cand0_d;
        s1_cand1 <= cand1_d;
        s1_c0    <= c0_d;
        s1_c1    <= c1_d;
      end
    end

    // Each segment picks its candidate by the resolved carry of the one below
    always_comb begin
      carry              = '0;
      res_sum            = '0;
      carry[0]           = s1_lo_c;
      res_sum[SEG-1:0]   = s1_lo_sum;
      for (int unsigned k = 1; k < NSEG; k++) begin
        res_sum[k*SEG +: SEG] = carry[k-1] ? s1_cand1[k] : s1_cand0[k];
        carry[k]              = carry[k-1] ? s1_c1[k] : s1_c0[k];
      end
    end

    assign res_cout = carry[NSEG-1];
  end else begin : g_single
    assign res_sum  = s1_lo_sum;
    assign res_cout = s1_lo_c;
  end

  assign ovf_d = (s1_a_msb == s1_b_msb) && (res_sum[WIDTH-1] != s1_a_msb);

  // Output stage holds its beat stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_sum;
        cout <= res_cout;
        ovf  <= ovf_d;
        zero <= (res_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Directed and streaming checks of pipe_csel_adder at 16/4, 32/8 and 64/16,
// with all three instances driven by the same stimulus.
module tb_pipe_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [63:0] xv;
  logic [63:0] yv;

  logic        rdy16, vld16, cout16, ovf16, zero16;
  logic [15:0] sum16;
  logic        rdy32, vld32, cout32, ovf32, zero32;
  logic [31:0] sum32;
  logic        rdy64, vld64, cout64, ovf64, zero64;
  logic [63:0] sum64;

  int n_vec = 0;
  int n_err = 0;
  int pops32 = 0;
  logic [66:0] q16[$];
  logic [66:0] q32[$];
  logic [66:0] q64[$];
  logic [66:0] e;

  always #5 clk = ~clk;

  pipe_csel_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .x(xv[15:0]), .y(yv[15:0]), .cin(cin), .sub(sub),
    .out_valid(vld16), .out_ready(out_ready), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  pipe_csel_adder #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .x(xv[31:0]), .y(yv[31:0]), .cin(cin), .sub(sub),
    .out_valid(vld32), .out_ready(out_ready), .sum(sum32),
    .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  pipe_csel_adder #(.WIDTH(64), .SEG(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .x(xv), .y(yv), .cin(cin), .sub(sub),
    .out_valid(vld64), .out_ready(out_ready), .sum(sum64),
    .cout(cout64), .ovf(ovf64), .zero(zero64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain wide-adder reference: returns {zero, ovf, cout, sum}
  function automatic logic [66:0] ref_add(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic ci,
                                          input logic s);
    logic [63:0] mask, am, bm, r;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + (s ? 65'd1 : 65'(ci));
    r    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    return {(r == 64'd0), ov, co, r};
  endfunction

  // Scoreboard: pop on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete(); q32.delete(); q64.delete();
    end else begin
      if (vld16 && out_ready) begin
        if (q16.size() == 0) chk("sb16_spurious", 64'(vld16), 64'd0);
        else begin
          e = q16.pop_front();
          chk("sb16_sum", 64'(sum16), e[63:0]);
          chk("sb16_flags", 64'({zero16, ovf16, cout16}), 64'(e[66:64]));
        end
      end
      if (vld32 && out_ready) begin
        if (q32.size() == 0) chk("sb32_spurious", 64'(vld32), 64'd0);
        else begin
          e = q32.pop_front();
          chk("sb32_sum", 64'(sum32), e[63:0]);
          chk("sb32_flags", 64'({zero32, ovf32, cout32}), 64'(e[66:64]));
          pops32++;
        end
      end
      if (vld64 && out_ready) begin
        if (q64.size() == 0) chk("sb64_spurious", 64'(vld64), 64'd0);
        else begin
          e = q64.pop_front();
          chk("sb64_sum", sum64, e[63:0]);
          chk("sb64_flags", 64'({zero64, ovf64, cout64}), 64'(e[66:64]));
        end
      end
      if (in_valid && rdy16) q16.push_back(ref_add(16, xv, yv, cin, sub));
      if (in_valid && rdy32) q32.push_back(ref_add(32, xv, yv, cin, sub));
      if (in_valid && rdy64) q64.push_back(ref_add(64, xv, yv, cin, sub));
    end
  end

  // One beat into an empty pipe; result must show after exactly two edges
  task automatic send1(input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic s);
    xv = a; yv = b; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat1_vld32", 64'(vld32), 64'd0);
    @(posedge clk); #1;
    chk("lat2_vld32", 64'(vld32), 64'd1);
    chk("lat2_vld16", 64'(vld16), 64'd1);
    chk("lat2_vld64", 64'(vld64), 64'd1);
  endtask

  task automatic expect32(input string tag, input logic [31:0] es, input logic [2:0] ef);
    chk({tag, "_sum"}, 64'(sum32), 64'(es));
    chk({tag, "_zoc"}, 64'({zero32, ovf32, cout32}), 64'(ef));
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q16.size() != 0 || q32.size() != 0 || q64.size() != 0); k++)
      @(posedge clk);
    #1;
    chk("drain_q16", 64'(q16.size()), 64'd0);
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);
  endtask

  logic [63:0] bp_x [5];
  logic [63:0] bp_y [5];
  logic        bp_s [5];
  logic        bp_c [5];

  initial begin
    int bi;
    int p0;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    xv = '0; yv = '0;
    #12;
    chk("rst_vld32", 64'(vld32), 64'd0);
    chk("rst_sum32", 64'(sum32), 64'd0);
    chk("rst_zoc32", 64'({zero32, ovf32, cout32}), 64'd0);
    chk("rst_rdy32", 64'(rdy32), 64'd1);
    chk("rst_vld16", 64'(vld16), 64'd0);
    chk("rst_vld64", 64'(vld64), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy32", 64'(rdy32), 64'd1);

    // Full-width ripple: all ones + 1 at every width
    send1(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    expect32("ripple32", 32'h0, 3'b101);
    chk("ripple16_sum", 64'(sum16), 64'd0);
    chk("ripple16_zoc", 64'({zero16, ovf16, cout16}), 64'b101);
    chk("ripple64_sum", sum64, 64'd0);
    chk("ripple64_zoc", 64'({zero64, ovf64, cout64}), 64'b101);

    send1(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
    expect32("posovf", 32'h8000_0000, 3'b010);
    send1(64'd5, 64'd7, 1'b0, 1'b1);
    expect32("sub_borrow", 32'hFFFF_FFFE, 3'b000);
    send1(64'd9, 64'd3, 1'b0, 1'b1);
    expect32("sub_noborrow", 32'd6, 3'b001);
    send1(64'd10, 64'd4, 1'b1, 1'b1);
    expect32("sub_cin_ign", 32'd6, 3'b001);
    send1(64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0);
    expect32("negovf", 32'h0, 3'b111);
    send1(64'h1234_5678, 64'h0000_00FF, 1'b1, 1'b0);
    expect32("cin_add", 32'h1234_5778, 3'b000);
    send1(64'h00FF_FF00, 64'h0000_0100, 1'b0, 1'b0);
    expect32("mid_ripple", 32'h0100_0000, 3'b000);
    drain();

    // Back-to-back random stream at full rate
    p0 = pops32;
    for (int i = 0; i < 100; i++) begin
      chk("rnd_rdy32", 64'(rdy32), 64'd1);
      if (i >= 2) chk("rnd_vld32", 64'(vld32), 64'd1);
      xv = {$urandom, $urandom}; yv = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("rnd_count32", 64'(pops32 - p0), 64'd100);

    // Backpressure: two beats fit, then in_ready drops and output holds
    bp_x[0] = 64'd100;         bp_y[0] = 64'd200;         bp_c[0] = 1'b0; bp_s[0] = 1'b0;
    bp_x[1] = 64'd1000;        bp_y[1] = 64'd1;           bp_c[1] = 1'b0; bp_s[1] = 1'b1;
    bp_x[2] = 64'hFFFF_FFFF;   bp_y[2] = 64'hFFFF_FFFF;   bp_c[2] = 1'b1; bp_s[2] = 1'b0;
    bp_x[3] = 64'h0F0F_0F0F;   bp_y[3] = 64'h1111_1111;   bp_c[3] = 1'b0; bp_s[3] = 1'b1;
    bp_x[4] = 64'h0000_0042;   bp_y[4] = 64'h0000_0024;   bp_c[4] = 1'b1; bp_s[4] = 1'b0;
    out_ready = 1'b0;
    bi = 0;
    for (int c = 0; c < 5; c++) begin
      xv = bp_x[bi]; yv = bp_y[bi]; cin = bp_c[bi]; sub = bp_s[bi]; in_valid = 1'b1;
      chk("bp_rdy32", 64'(rdy32), (c < 2) ? 64'd1 : 64'd0);
      if (c >= 2) begin
        chk("bp_hold_vld32", 64'(vld32), 64'd1);
        chk("bp_hold_sum32", 64'(sum32), 64'd300);
      end
      acc = rdy32;
      @(posedge clk); #1;
      if (acc) bi++;
    end
    chk("bp_accepted", 64'(bi), 64'd2);
    out_ready = 1'b1;
    xv = bp_x[bi]; yv = bp_y[bi]; cin = bp_c[bi]; sub = bp_s[bi];
    acc = rdy32;
    @(posedge clk); #1;
    if (acc) bi++;
    chk("bp_next_vld32", 64'(vld32), 64'd1);
    chk("bp_next_sum32", 64'(sum32), 64'd999);
    for (int k = 0; k < 20 && bi < 5; k++) begin
      xv = bp_x[bi]; yv = bp_y[bi]; cin = bp_c[bi]; sub = bp_s[bi];
      acc = rdy32;
      @(posedge clk); #1;
      if (acc) bi++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(bi), 64'd5);
    drain();

    // Reset with two beats in flight
    xv = 64'd1; yv = 64'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    xv = 64'd3; yv = 64'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_vld32", 64'(vld32), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld32", 64'(vld32), 64'd0);
    chk("mid_rst_sum32", 64'(sum32), 64'd0);
    chk("mid_rst_rdy32", 64'(rdy32), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("no_stale_vld32", 64'(vld32), 64'd0);
      chk("no_stale_vld64", 64'(vld64), 64'd0);
    end
    send1(64'h11, 64'h22, 1'b0, 1'b0);
    expect32("post_rst", 32'h33, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
